nand_share_arbiter: RTL and testbench
=====================================

Name: nand_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one bitwise DATA_W-wide NAND evaluation stage among NUM_REQ requesters in the detection-logic path. Each requester offers an operand pair using a valid/ready handshake. The block grants one requester per cycle, computes Y = ~(A & B) into a single result register, and returns the result tagged with the requester ID over a valid/ready response channel.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
DATA_W, 8, operand and result width in bits.
ID_W, $clog2(NUM_REQ), width of the requester ID tag; derived, not overridden.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester operand-valid.
req_ready  out  NUM_REQ  per-requester grant/accept; one-hot or zero.
req_a  in  NUM_REQ*DATA_W  packed operand A; requester i occupies bits [i*DATA_W +: DATA_W].
req_b  in  NUM_REQ*DATA_W  packed operand B; same packing as req_a.
rsp_valid  out  1  result register holds a valid result.
rsp_ready  in  1  downstream accepts the result.
rsp_data  out  DATA_W  NAND result, ~(A & B), bitwise.
rsp_id  out  ID_W  index of the requester that produced rsp_data.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): rsp_valid=0, rsp_data=0, rsp_id=0, round-robin pointer=0.
- req_ready is combinational, with no dependency on req_valid of the same requester beyond the arbitration. It is zero during reset.
- Slot free = !rsp_valid || rsp_ready.
- Grant: when the slot is free and any req_valid is set, pick the first set req_valid at or after the pointer, wrapping modulo NUM_REQ. Assert req_ready for that requester only. No grant when the slot is not free.
- Transfer on req_valid[i] && req_ready[i].
- Capture on the next edge: rsp_data = ~(A_i & B_i), rsp_id = i, rsp_valid = 1.
- Pointer moves to (i+1) mod NUM_REQ on a grant. It is unchanged otherwise.
- Latency: 1 cycle from accept to rsp_valid.
- Throughput: 1 result per cycle while rsp_ready is held high.
- rsp_valid with !rsp_ready: rsp_data and rsp_id hold stable and no req_ready is asserted (backpressure).
- Simultaneous rsp_ready and a new grant in one cycle: the old result is consumed and the new result is loaded on the same edge, with no bubble.
- rsp_ready with no pending request: rsp_valid clears next cycle; rsp_data holds its last value.
- Requesters may drop req_valid without a grant; no state is affected.
- Reset mid-operation: any pending result is discarded immediately and the pointer returns to 0.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- State machine, two states:
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on rsp_ready with no grant.
  - FULL stays FULL on a grant with rsp_ready, or on !rsp_ready.
  - rsp_valid is the state bit.

Optional Feature:
Macro NAND_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (NUM_REQ*16 bits): per-requester 16-bit grant counters.
  - Adds output stall_cnt (16 bits): counts cycles with any req_valid set while the slot is not free.
  - All counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and logic are absent, with identical functional behaviour otherwise.

Decomposition:
- Shared package nand_arb_pkg holds:
  - the default NUM_REQ and DATA_W constants;
  - the state enum {EMPTY, FULL};
  - the counter width constant STAT_W=16.
- One sub-module, rr_arbiter: the pure round-robin grant logic (req vector and pointer in; one-hot grant and granted index out).

Test Plan:
- After reset release with all req_valid=0: rsp_valid=0, req_ready=0, rsp_data=0.
- Requester 2 with A=8'hF0, B=8'h3C, rsp_ready=1: req_ready=4'b0100. The next cycle gives rsp_valid=1, rsp_data=8'hCF, rsp_id=2.
- All four req_valid held with rsp_ready=1: grants in order 0,1,2,3,0 on consecutive cycles, one result per cycle, no bubbles.
- rsp_ready=0 for 3 cycles after one result: rsp_data and rsp_id stay stable and req_ready=0 throughout. On the cycle rsp_ready rises, a new grant is accepted and the next result appears the following cycle.
- rst_n pulsed low while rsp_valid=1 and the pointer is at 3: rsp_valid drops immediately. After release, the first grant with all requesters valid goes to requester 0.
- With NAND_ARB_STATS_EN, 5 grants to requester 1 and 2 stall cycles: grant_cnt[1]=5 and stall_cnt=2. Preloading near 16'hFFFF confirms the counters saturate.

Source files
------------

// File: rtl/nand_share_arbiter_pkg.sv
// nand_arb_pkg: shared constants and types for the NAND share arbiter.
//   NUM_REQ_DEF / DATA_W_DEF : default requester count and operand width
//   STAT_W                   : width of the optional statistics counters
//   arb_state_e              : result-slot state (EMPTY / FULL)
package nand_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned STAT_W      = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/nand_share_arbiter_if.sv
// nand_share_arbiter_if: requester and response channels of the NAND share arbiter.
//   req_valid / req_ready : per-requester operand handshake (ready is one-hot or zero)
//   req_a / req_b         : packed operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid / rsp_ready : result handshake
//   rsp_data / rsp_id     : NAND result and index of the requester that produced it
// Modports: master = requesters + downstream consumer, slave = arbiter.
interface nand_share_arbiter_if
  import nand_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/nand_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   gnt       : one-hot grant (zero when no request)
//   gnt_idx   : index of the granted requester
//   gnt_valid : any grant issued
module rr_arbiter
  import nand_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_valid
);

  // Scan from ptr upward, wrapping; the first set request wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = ID_W'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nand_share_arbiter.sv
// nand_share_arbiter: shares one DATA_W-wide NAND stage among NUM_REQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : nand_share_arbiter_if.slave (request and response channels)
//   grant_cnt  : per-requester saturating grant counters (NAND_ARB_STATS_EN only)
//   stall_cnt  : saturating count of cycles with a request while the slot is busy
//                (NAND_ARB_STATS_EN only)
// Optional feature macro: NAND_ARB_STATS_EN.
module nand_share_arbiter
  import nand_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  nand_share_arbiter_if.slave bus
`ifdef NAND_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt,
  output logic [STAT_W-1:0]         stall_cnt
`endif
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam logic StEmpty = EMPTY;
  localparam logic StFull  = FULL;

  logic              state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [DATA_W-1:0] data_q;
  logic [ID_W-1:0]   id_q;

  logic               slot_free;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_valid;
  logic [ID_W-1:0]    ptr_nxt;
  logic [DATA_W-1:0]  opnd_a;
  logic [DATA_W-1:0]  opnd_b;

  assign slot_free = (state_q == StEmpty) || bus.rsp_ready;
  // Masking with rst_n keeps req_ready low while reset is asserted.
  assign arb_req   = bus.req_valid & {NUM_REQ{slot_free && rst_n}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (arb_req),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign opnd_a  = bus.req_a[gnt_idx*DATA_W +: DATA_W];
  assign opnd_b  = bus.req_b[gnt_idx*DATA_W +: DATA_W];
  assign ptr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else if (gnt_valid) begin
      // A grant implies the slot is free, so loading here also consumes the old result.
      state_q <= StFull;
      ptr_q   <= ptr_nxt;
      data_q  <= ~(opnd_a & opnd_b);
      id_q    <= gnt_idx;
    end else if (bus.rsp_ready) begin
      state_q <= StEmpty;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = state_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;

`ifdef NAND_ARB_STATS_EN
  logic [STAT_W-1:0] gcnt_q [NUM_REQ];
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        gcnt_q[i] <= '0;
      end
      stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && (gcnt_q[i] != {STAT_W{1'b1}})) begin
          gcnt_q[i] <= gcnt_q[i] + 1'b1;
        end
      end
      if ((|bus.req_valid) && !slot_free && (stall_q != {STAT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*STAT_W +: STAT_W] = gcnt_q[g];
  end
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_nand_share_arbiter.sv
module tb_nand_share_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam logic [N-1:0] ONE = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nand_share_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

`ifdef NAND_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  nand_share_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef NAND_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the result slot as a value/valid pair plus a priority pointer.
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [1:0]   m_id;
  int           m_ptr;
  int           exp_g;
  logic [N-1:0] exp_ready;
`ifdef NAND_ARB_STATS_EN
  int m_gcnt [N];
  int m_stall;
`endif

  // Which requester should be granted now (-1: none).
  function automatic int exp_grant(input logic rn, input logic v, input logic rdy,
                                   input logic [N-1:0] rv, input int p);
    if (!rn) return -1;
    if (v && !rdy) return -1;
    for (int k = 0; k < N; k++) begin
      if (rv[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  assign exp_g     = exp_grant(rst_n, m_valid, bus.rsp_ready, bus.req_valid, m_ptr);
  assign exp_ready = (exp_g >= 0) ? (ONE << exp_g) : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_id    <= '0;
      m_ptr   <= 0;
`ifdef NAND_ARB_STATS_EN
      for (int i = 0; i < N; i++) m_gcnt[i] <= 0;
      m_stall <= 0;
`endif
    end else begin
      if (exp_g >= 0) begin
        m_valid <= 1'b1;
        m_data  <= ~(bus.req_a[exp_g*W +: W] & bus.req_b[exp_g*W +: W]);
        m_id    <= exp_g[1:0];
        m_ptr   <= (exp_g + 1) % N;
      end else if (bus.rsp_ready) begin
        m_valid <= 1'b0;
      end
`ifdef NAND_ARB_STATS_EN
      if (exp_g >= 0 && m_gcnt[exp_g] < 65535) m_gcnt[exp_g] <= m_gcnt[exp_g] + 1;
      if ((|bus.req_valid) && m_valid && !bus.rsp_ready && m_stall < 65535)
        m_stall <= m_stall + 1;
`endif
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    check("rsp_data",  32'(bus.rsp_data),  32'(m_data));
    check("rsp_id",    32'(bus.rsp_id),    32'(m_id));
  end

  logic [N-1:0] oh;

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check("in_reset_valid", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    @(negedge clk);
    check("idle_valid", 32'(bus.rsp_valid), 32'h0);
    check("idle_ready", 32'(bus.req_ready), 32'h0);
    check("idle_data",  32'(bus.rsp_data),  32'h0);
    @(posedge clk); #1;

    // All requesters valid: grants rotate 0,1,2,3,0 with a result every cycle.
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = 8'(8'h11 * (i + 1));
      bus.req_b[i*W +: W] = 8'(8'hF0 ^ i);
    end
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      oh = ONE << (k % N);
      check("rr_grant", 32'(bus.req_ready), 32'(oh));
      if (k > 0) begin
        check("rr_id",    32'(bus.rsp_id),    32'((k - 1) % N));
        check("rr_valid", 32'(bus.rsp_valid), 32'h1);
      end
      @(posedge clk); #1;
    end

    // Requester 2 alone: ~(F0 & 3C) = CF. Pointer is at 1 here.
    bus.req_valid = 4'b0100;
    bus.req_a[2*W +: W] = 8'hF0;
    bus.req_b[2*W +: W] = 8'h3C;
    @(negedge clk);
    check("r2_ready", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1;

    // Backpressure for three cycles with everyone requesting.
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_data",  32'(bus.rsp_data),  32'hCF);
      check("bp_id",    32'(bus.rsp_id),    32'h2);
      check("bp_ready", 32'(bus.req_ready), 32'h0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 32'(bus.req_ready), 32'h8);
    @(posedge clk); #1;
    // Requester 3 result: ~(44 & F3) = BF; then grant 2 to leave the pointer at 3.
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("r3_data", 32'(bus.rsp_data), 32'hBF);
    check("r3_id",   32'(bus.rsp_id),   32'h3);
    check("r2b_grant", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1;

    // Reset mid-operation with a pending result.
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(bus.rsp_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1 check("rst_drop_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid = N'($urandom);
      bus.req_a     = $urandom;
      bus.req_b     = $urandom;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n         = ($urandom_range(0, 149) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);

`ifdef NAND_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(m_gcnt[i]));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
